// File: rtl/iir_result_capture_pkg.sv
// Shared definitions for the IIR result capture block.
// Holds the capture FSM state encoding and default sample and address widths.
package iir_result_capture_pkg;

    localparam int DW_DEF = 24;  // sample width, signed
    localparam int AW_DEF = 11;  // address width, DEPTH = 2**AW

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2,
        ST_DRAIN   = 2'd3
    } cap_state_e;

endpackage

// File: rtl/iir_result_capture_if.sv
// Sample stream and drain read port of the result capture block.
//   data_in / data_in_valid : filter output stream into the capture block (no backpressure)
//   rd_ready                : consumer accepts rd_data
//   rd_valid / rd_data / rd_last : drained word, rd_last marks the final word
// Modport slave is the capture block side; master is the producer/consumer side.
interface iir_result_capture_if #(
    parameter int DW = 24
) ();
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;

    modport slave (
        input  data_in, data_in_valid, rd_ready,
        output rd_valid, rd_data, rd_last
    );

    modport master (
        output data_in, data_in_valid, rd_ready,
        input  rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/iir_result_capture_ram.sv
// Simple dual-port synchronous RAM, DEPTH = 2**AW words of DW bits.
//   clk, rst_n       : clock, async active-low reset (read register only)
//   we, waddr, wdata : write port
//   re, raddr        : read request; rdata valid the cycle after re
//   rdata            : registered read data, holds its value while re is low
module iir_result_capture_ram #(
    parameter int DW = 24,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // The read register doubles as the drain output register, so it gets a
    // reset to present rd_data = 0 out of reset; the array itself has none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/iir_result_capture.sv
// Result capture sink for the IIR filter output stream.
// Arm -> capture DEPTH samples into RAM -> capture_done -> drain over a
// valid/ready port (one word every two cycles). A settling detector runs
// alongside the capture and sets stable_out after STABLE_WIN consecutive
// sample-to-sample deltas within +/-STABLE_TOL.
//   clk, rst_n    : clock, async active-low reset
//   arm           : one-cycle pulse, starts/restarts a capture
//   bus (slave)   : sample stream in, drain read port out
//   wr_addr       : next write index (samples captured so far)
//   capture_done  : buffer full, held until the last word is drained
//   overrun       : sticky, sample arrived while buffer full/draining
//   stable_out    : sticky, settling seen during this capture
module iir_result_capture
    import iir_result_capture_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int AW         = AW_DEF,
    parameter int STABLE_WIN = 16,
    parameter int STABLE_TOL = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    iir_result_capture_if.slave  bus,
    output logic [AW-1:0]        wr_addr,
    output logic                 capture_done,
    output logic                 overrun,
    output logic                 stable_out
);
    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam int            CW        = $clog2(STABLE_WIN + 1);

    cap_state_e state, state_nxt;

    logic          start, wr_en, rd_issue, rd_hs, ovr_set;
    logic [AW-1:0] rd_addr;
    logic          rd_valid_q, rd_last_q;
    logic [DW-1:0] ram_q;

    logic [DW-1:0] prev;
    logic          have_prev;
    logic [CW-1:0] stab_cnt, cnt_nxt;
    logic [DW:0]   delta, mag;
    logic          in_tol;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        wr_en     = 1'b0;
        rd_issue  = 1'b0;
        rd_hs     = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm) begin
                    start     = 1'b1;
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // A restart takes precedence over a sample in the same cycle.
                if (arm) begin
                    start = 1'b1;
                end else if (bus.data_in_valid) begin
                    wr_en = 1'b1;
                    if (wr_addr == LAST_ADDR) state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                rd_issue  = 1'b1;
                ovr_set   = bus.data_in_valid;
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                ovr_set = bus.data_in_valid;
                // Read issue and handshake alternate, giving one word per two cycles.
                if (rd_valid_q) begin
                    if (bus.rd_ready) begin
                        rd_hs = 1'b1;
                        if (rd_last_q) state_nxt = ST_IDLE;
                    end
                end else begin
                    rd_issue = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- stability detector ----------------
    // Deltas are taken one bit wider than the samples so full-scale swings
    // (e.g. 0x7FFFFF -> 0x800000) cannot wrap into a small magnitude.
    always_comb begin
        delta = {bus.data_in[DW-1], bus.data_in} - {prev[DW-1], prev};
        mag   = delta[DW] ? (~delta + (DW+1)'(1)) : delta;
        in_tol = (mag <= (DW+1)'(STABLE_TOL));
        if (!in_tol)                            cnt_nxt = '0;
        else if (stab_cnt == CW'(STABLE_WIN))   cnt_nxt = stab_cnt;
        else                                    cnt_nxt = stab_cnt + CW'(1);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr      <= '0;
            capture_done <= 1'b0;
            overrun      <= 1'b0;
            stable_out   <= 1'b0;
            rd_addr      <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            prev         <= '0;
            have_prev    <= 1'b0;
            stab_cnt     <= '0;
        end else begin
            if (start) begin
                wr_addr    <= '0;
                rd_addr    <= '0;
                overrun    <= 1'b0;
                stable_out <= 1'b0;
                have_prev  <= 1'b0;
                stab_cnt   <= '0;
            end
            if (wr_en) begin
                wr_addr   <= wr_addr + AW'(1);  // wraps to 0 after the last index
                prev      <= bus.data_in;
                have_prev <= 1'b1;
                if (wr_addr == LAST_ADDR) capture_done <= 1'b1;
                // The first sample after arm only seeds prev.
                if (have_prev) begin
                    stab_cnt <= cnt_nxt;
                    if (cnt_nxt == CW'(STABLE_WIN)) stable_out <= 1'b1;
                end
            end
            if (ovr_set) overrun <= 1'b1;
            if (rd_issue) begin
                rd_valid_q <= 1'b1;
                rd_last_q  <= (rd_addr == LAST_ADDR);
            end
            if (rd_hs) begin
                rd_valid_q <= 1'b0;
                rd_addr    <= rd_addr + AW'(1);
                if (rd_last_q) begin
                    capture_done <= 1'b0;
                    rd_last_q    <= 1'b0;
                end
            end
        end
    end

    iir_result_capture_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.data_in),
        .re    (rd_issue),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    assign bus.rd_data  = ram_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
endmodule

// File: tb/tb_iir_result_capture.sv
// Self-checking bench for iir_result_capture: reset, idle rejection, ramp
// capture/drain, random backpressure, settling detection, rearm and overrun,
// async reset during drain. A sample-list model predicts every output.
module tb_iir_result_capture;
    localparam int DW    = 24;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;
    localparam int WIN   = 16;
    localparam int TOL   = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm;
    logic [AW-1:0] wr_addr;
    logic          capture_done, overrun, stable_out;

    iir_result_capture_if #(.DW(DW)) bus ();

    iir_result_capture #(.DW(DW), .AW(AW), .STABLE_WIN(WIN), .STABLE_TOL(TOL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .bus          (bus),
        .wr_addr      (wr_addr),
        .capture_done (capture_done),
        .overrun      (overrun),
        .stable_out   (stable_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [DW-1:0] exp_mem [DEPTH];
    int  widx;
    bit  have_prev;
    int  prev_s;
    int  run;
    bit  stab_exp;
    bit  ovr_exp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_arm();
        widx = 0; have_prev = 0; run = 0; stab_exp = 0; ovr_exp = 0;
    endtask

    task automatic reset_checks();
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_done", capture_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_stable", stable_out, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_last", bus.rd_last, 0);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
        model_arm();
        chk("arm_wr_addr", wr_addr, 0);
        chk("arm_stable", stable_out, 0);
        chk("arm_overrun", overrun, 0);
        chk("arm_done", capture_done, 0);
    endtask

    task automatic feed_sample(input logic [DW-1:0] v, input int gap);
        bus.data_in       = v;
        bus.data_in_valid = 1'b1;
        step();
        bus.data_in_valid = 1'b0;
        exp_mem[widx] = v;
        if (have_prev) begin
            int d;
            d = sx(v) - prev_s;
            if (d < 0) d = -d;
            if (d <= TOL) run++;
            else          run = 0;
            if (run >= WIN) stab_exp = 1;
        end
        have_prev = 1;
        prev_s    = sx(v);
        widx++;
        if (widx == DEPTH) begin
            chk("done_set", capture_done, 1);
            chk("wr_wrap", wr_addr, 0);
        end else begin
            chk("wr_addr", wr_addr, widx);
            chk("done_low", capture_done, 0);
        end
        chk("stable", stable_out, stab_exp);
        if (widx < DEPTH) repeat ($urandom_range(0, gap)) step();
    endtask

    function automatic logic [DW-1:0] gen(input int mode, input int n);
        case (mode)
            0:       return DW'(n * 1000);
            2:       return DW'(100 + $urandom_range(0, 10));
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic capture(input int mode, input int gap, input int upto);
        while (widx < upto) feed_sample(gen(mode, widx), gap);
    endtask

    // Drain with rd_ready high pct% of cycles; optionally inject 'extra'
    // valid samples; stop_at >= 0 abandons the drain at that word index.
    task automatic drain(input int pct, input int extra, input int stop_at);
        int k = 0;
        int cyc = 0;
        int extra_left = extra;
        bit stalled = 0;
        bit rdy;
        logic [DW-1:0] held = '0;
        if (extra > 0) ovr_exp = 1;
        while (k < DEPTH && cyc < 40000) begin
            if (stop_at >= 0 && k == stop_at) break;
            if (stalled) begin
                chk("hold_valid", bus.rd_valid, 1);
                chk("hold_data", bus.rd_data, held);
            end
            rdy = ($urandom_range(0, 99) < pct);
            bus.rd_ready = rdy;
            if (extra_left > 0) begin
                bus.data_in_valid = 1'b1;
                bus.data_in       = DW'($urandom);
                extra_left--;
            end else begin
                bus.data_in_valid = 1'b0;
            end
            stalled = 0;
            if (bus.rd_valid) begin
                if (rdy) begin
                    chk("rd_data", bus.rd_data, exp_mem[k]);
                    chk("rd_last", bus.rd_last, (k == DEPTH - 1));
                    k++;
                end else begin
                    stalled = 1;
                    held    = bus.rd_data;
                end
            end else begin
                chk("last_idle", bus.rd_last, 0);
            end
            step();
            cyc++;
        end
        bus.rd_ready      = 1'b0;
        bus.data_in_valid = 1'b0;
        if (stop_at < 0) begin
            chk("drain_count", k, DEPTH);
            chk("drain_done_clr", capture_done, 0);
            chk("drain_valid_clr", bus.rd_valid, 0);
            chk("drain_last_clr", bus.rd_last, 0);
            chk("overrun", overrun, ovr_exp);
            // back in IDLE: samples are ignored
            bus.data_in_valid = 1'b1;
            bus.data_in       = DW'($urandom);
            repeat (3) step();
            bus.data_in_valid = 1'b0;
            chk("idle_wr_addr", wr_addr, 0);
            chk("idle_overrun", overrun, ovr_exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        arm   = 1'b0;
        bus.data_in       = '0;
        bus.data_in_valid = 1'b0;
        bus.rd_ready      = 1'b0;
        model_arm();

        // reset state, then samples without arm are ignored
        repeat (3) begin
            step();
            reset_checks();
        end
        rst_n = 1'b1;
        step();
        repeat (100) begin
            bus.data_in_valid = 1'b1;
            bus.data_in       = DW'($urandom);
            step();
        end
        bus.data_in_valid = 1'b0;
        step();
        chk("noarm_wr_addr", wr_addr, 0);
        chk("noarm_overrun", overrun, 0);
        chk("noarm_done", capture_done, 0);

        // ramp capture, full-rate drain
        do_arm();
        capture(0, 0, DEPTH);
        drain(100, 0, -1);

        // random data with gaps, 30% rd_ready
        do_arm();
        capture(1, 2, DEPTH);
        drain(30, 0, -1);

        // settling: full-scale alternation then a constant
        do_arm();
        for (int i = 0; i < 20; i++) feed_sample((i % 2) ? 24'h800000 : 24'h7FFFFF, 0);
        for (int i = 0; i < 20; i++) feed_sample(24'd5, 0);
        chk("stab_final", stable_out, 1);
        do_arm();

        // rearm mid-capture with a simultaneous sample, then overrun during drain
        capture(1, 1, 500);
        chk("pre_rearm_wr", wr_addr, 500);
        arm = 1'b1;
        bus.data_in_valid = 1'b1;
        bus.data_in       = DW'($urandom);
        step();
        arm = 1'b0;
        bus.data_in_valid = 1'b0;
        model_arm();
        chk("rearm_wr", wr_addr, 0);
        chk("rearm_overrun", overrun, 0);
        capture(1, 1, DEPTH);
        drain(100, 10, -1);
        do_arm();

        // async reset in the middle of a drain, then a normal capture
        capture(1, 0, DEPTH);
        drain(50, 0, 1000);
        #2 rst_n = 1'b0;
        #1 reset_checks();
        model_arm();
        step();
        rst_n = 1'b1;
        step();
        do_arm();
        capture(2, 1, DEPTH);
        drain(100, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
